// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for the 8-bit up-counter datapath.
// Accepts CLEAR / LOAD / RUN n / UNTIL target over a valid/ready handshake, drives the
// counter's clear/load/enable controls and pulses done for one cycle on completion.
// Optional feature: define COUNTER_SEQ_ABORT_EN to let abort cut RUN/UNTIL short.
module counter_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StLoad,
      StRun,
      StUntil,
      StDone
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] arg_q;
   logic [WIDTH-1:0] remain_q;
   logic             abort_req;

`ifdef COUNTER_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   // abort is present on the port but has no effect in this build
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_req    = 1'b0;
`endif

   // Sequencer FSM: command acceptance, tick countdown and target matching
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         arg_q    <= '0;
         remain_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  arg_q    <= cmd_arg;
                  // remain mirrors the latched argument so RUN starts with the full count
                  remain_q <= cmd_arg;
                  unique case (cmd_op)
                     2'b00:   state_q <= StClr;
                     2'b01:   state_q <= StLoad;
                     2'b10:   state_q <= (cmd_arg != '0) ? StRun : StDone;
                     default: state_q <= StUntil;
                  endcase
               end
            end
            StClr, StLoad: begin
               state_q <= StDone;
            end
            StRun: begin
               remain_q <= remain_q - 1'b1;
               if (abort_req || (remain_q == WIDTH'(1))) begin
                  state_q <= StDone;
               end
            end
            StUntil: begin
               if (abort_req || (cnt_value == arg_q)) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Output decode from the state register; UNTIL enable also looks at the live count
   always_comb begin
      cmd_ready    = (state_q == StIdle);
      busy         = (state_q != StIdle);
      cnt_clr      = (state_q == StClr);
      cnt_load     = (state_q == StLoad);
      cnt_load_val = (state_q == StLoad) ? arg_q : '0;
      cnt_en       = (state_q == StRun) ||
                     ((state_q == StUntil) && (cnt_value != arg_q));
      done         = (state_q == StDone);
   end

endmodule
